cfg_word_loader: RTL and testbench
==================================

# cfg_word_loader

Bitstream word loader that sits directly upstream of the fabric configuration port (`SelfWriteData`/`SelfWriteStrobe`) of `eFPGA_top`. It accepts a byte stream over a valid/ready handshake and packs every four bytes big-endian (first byte → bits 31:24). It presents each word to the fabric with programmable setup and hold spacing around a one-cycle write strobe, and raises a completion pulse after a programmed number of bytes. It replaces the bench-side byte-to-word loop so that on-chip sources (UART, SPI flash, ROM) can configure the fabric.

## Interface
- `SETUP_CYCLES`, 2: cycles `SelfWriteData` is held stable before the strobe; legal range ≥1.
- `HOLD_CYCLES`, 2: cycles `SelfWriteData` is held stable after the strobe; legal range ≥1.
- `LEN_W`, 16: width of the byte-count input.
- `CLK`  in  1  single clock; all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load. Ignored unless the block is idle.
- `byte_count`  in  LEN_W  total bytes to load; sampled on an accepted `start`.
- `in_byte`  in  8  stream data.
- `in_valid`  in  1  `in_byte` is valid.
- `in_ready`  out  1  block accepts a byte this cycle.
- `SelfWriteData`  out  32  configuration word to the fabric.
- `SelfWriteStrobe`  out  1  one-cycle write strobe to the fabric.
- `busy`  out  1  high from an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a load.
- `words_written`  out  LEN_W-2  strobes issued since the last accepted `start`.

## Operation
- States: IDLE, COLLECT, SETUP, STROBE, HOLD, DONE.
- **IDLE**
  - `start`=1 with `byte_count`≠0: latch `remaining`=`byte_count`, clear the packer, clear `words_written`, go to COLLECT.
  - `start`=1 with `byte_count`=0: go to DONE.
- **COLLECT**
  - `in_ready`=1.
  - Each handshake (`in_valid`&`in_ready`):
    - the byte goes into lane `byte_idx` (lane 0 = bits 31:24);
    - `byte_idx`++ and `remaining`--.
  - A word is complete when `byte_idx` reaches 4 or `remaining` reaches 0. On that accepting edge:
    - load `SelfWriteData` with the packed word, with unfilled low lanes zero-padded;
    - reset `byte_idx` to 0 and go to SETUP.
- **SETUP**
  - Lasts SETUP_CYCLES cycles, counted by the timer.
  - Then go to STROBE.
- **STROBE**
  - Lasts 1 cycle with `SelfWriteStrobe`=1.
  - `words_written` increments on exit.
  - Then go to HOLD.
- **HOLD**
  - Lasts HOLD_CYCLES cycles.
  - Then go to COLLECT if `remaining`≠0, else go to DONE.
- **DONE**
  - Lasts 1 cycle with `done`=1.
  - Then go to IDLE.
- `SelfWriteData` changes only on a word-complete edge. It holds its value through SETUP/STROBE/HOLD and after the load ends.
- `in_ready`=0 in every state except COLLECT. No input buffering.
- `start` is ignored in every state other than IDLE, including DONE.
- `words_written` saturates at all-ones and is never wrapped.
- `remaining` arithmetic is LEN_W-bit unsigned and never underflows, because bytes are accepted only while `remaining`≠0.

## Timing
- Reset values: `in_ready`=0, `SelfWriteData`=0, `SelfWriteStrobe`=0, `busy`=0, `done`=0, `words_written`=0, state IDLE.
- Asserting `resetn` mid-load drops all outputs to their reset values immediately and asynchronously. Any partial word is discarded and no further strobe is issued.
- Accepted `start` at edge T: `busy`=1 and `in_ready`=1 from T+1.
- Final byte of a word accepted at edge E:
  - `SelfWriteData` is valid from E;
  - `SelfWriteStrobe`=1 in cycle E+SETUP_CYCLES+1;
  - the next `in_ready`=1 comes at E+SETUP_CYCLES+HOLD_CYCLES+2.
- Steady state with `in_valid` always high: 4+SETUP_CYCLES+1+HOLD_CYCLES cycles per word, which is 9 at the defaults.
- `done` asserts in the cycle after the final HOLD cycle. `busy` falls on the same edge that `done` falls.
- For `byte_count`=0: `done` at T+1, no strobe issued.

## Structure
- Package `cfg_loader_pkg`:
  - state enum `cfg_state_t`;
  - constants `CFG_WORD_BYTES`=4 and `CFG_WORD_W`=32.
- Sub-module `cfg_hold_timer`: a loadable down-counter with load value and `expired` output, shared by SETUP and HOLD.
- Packer, remaining counter and word counter are implemented inline.

## Test plan
- **Basic load:** `byte_count`=8, bytes 01..08 streamed with `in_valid` held high.
  - Two strobes, carrying `SelfWriteData`=0x01020304 then 0x05060708.
  - Strobes 9 cycles apart.
  - `words_written`=2, then a single `done` pulse.
- **Partial final word:** `byte_count`=5, bytes AA BB CC DD EE.
  - Second strobe carries 0xEE000000.
  - `done` follows after HOLD_CYCLES+1 cycles.
- **Bursty source:** `in_valid` toggled pseudo-randomly, `byte_count`=12.
  - Words are identical to the contiguous case and no bytes are lost.
  - Data is stable for ≥2 cycles before and ≥2 cycles after each strobe.
- **Zero length:** `byte_count`=0.
  - `done` at T+1, no strobe, `in_ready` stays 0.
- **Start while busy:** a second `start` is pulsed during HOLD of word 1.
  - It is ignored; the load completes with the original count.
- **Reset mid-load:** `resetn` low during SETUP of word 2.
  - All outputs are 0 within the same cycle, with no strobe.
  - A subsequent `start` loads cleanly from lane 0.

Source files
------------

// File: rtl/cfg_word_loader_pkg.sv
// Shared types and constants for the configuration word loader.
// Holds the FSM state encoding and the byte-lane insert helper used by the packer.
package cfg_loader_pkg;

   localparam int CFG_WORD_BYTES = 4;
   localparam int CFG_WORD_W     = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_COLLECT = 3'd1,
      ST_SETUP   = 3'd2,
      ST_STROBE  = 3'd3,
      ST_HOLD    = 3'd4,
      ST_DONE    = 3'd5
   } cfg_state_t;

   // Lane 0 is the most significant byte, so the first byte lands in bits 31:24.
   function automatic logic [CFG_WORD_W-1:0] cfg_put_lane(
      input logic [CFG_WORD_W-1:0] word,
      input logic [1:0]            lane,
      input logic [7:0]            data
   );
      logic [CFG_WORD_W-1:0] w;
      w = word;
      case (lane)
         2'd0:    w[31:24] = data;
         2'd1:    w[23:16] = data;
         2'd2:    w[15:8]  = data;
         default: w[7:0]   = data;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/cfg_word_loader_timer.sv
// Loadable down-counter shared by the SETUP and HOLD phases.
// expired is registered and reflects the counter value held after each edge.
module cfg_hold_timer #(
   parameter int W = 2
) (
   input  logic         CLK,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] count_r;
   logic [W-1:0] count_nxt_s;
   logic         expired_r;

   // next count: reload takes priority, otherwise count down and stick at zero
   always_comb begin
      count_nxt_s = count_r;
      if (load) begin
         count_nxt_s = load_val;
      end else if (count_r != {W{1'b0}}) begin
         count_nxt_s = count_r - W'(1);
      end else begin
         count_nxt_s = count_r;
      end
   end

   // counter and registered expiry flag
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         count_r   <= {W{1'b0}};
         expired_r <= 1'b1;
      end else begin
         count_r   <= count_nxt_s;
         expired_r <= (count_nxt_s == {W{1'b0}});
      end
   end

   assign expired = expired_r;

endmodule

// File: rtl/cfg_word_loader.sv
// Byte-stream to 32-bit configuration word loader for the eFPGA self-write port.
// Packs bytes big-endian and frames each word with setup/strobe/hold spacing.
module cfg_word_loader
   import cfg_loader_pkg::*;
#(
   parameter int SETUP_CYCLES = 2,
   parameter int HOLD_CYCLES  = 2,
   parameter int LEN_W        = 16
) (
   input  logic                  CLK,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [LEN_W-1:0]      byte_count,
   input  logic [7:0]            in_byte,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [CFG_WORD_W-1:0] SelfWriteData,
   output logic                  SelfWriteStrobe,
   output logic                  busy,
   output logic                  done,
   output logic [LEN_W-3:0]      words_written
);

   localparam int CNT_W   = LEN_W - 2;
   localparam int TMR_MAX = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   cfg_state_t            state_r;
   logic [LEN_W-1:0]      rem_r;
   logic [CFG_WORD_W-1:0] pack_r;
   logic [1:0]            idx_r;
   logic [CFG_WORD_W-1:0] wdata_r;
   logic                  in_ready_r;
   logic                  strobe_r;
   logic                  busy_r;
   logic                  done_r;
   logic [CNT_W-1:0]      ww_r;

   logic                  accept_s;
   logic                  last_s;
   logic [CFG_WORD_W-1:0] packed_s;
   logic                  tmr_load_s;
   logic [TMR_W-1:0]      tmr_val_s;
   logic                  tmr_expired_s;

   // in_ready_r is only ever high in COLLECT, so it doubles as the handshake qualifier
   assign accept_s = in_valid & in_ready_r;
   assign last_s   = (idx_r == 2'd3) || (rem_r == LEN_W'(1));
   assign packed_s = cfg_put_lane(pack_r, idx_r, in_byte);

   // timer reload on entry to SETUP and HOLD; both phases count N-1 down to zero
   always_comb begin
      tmr_load_s = 1'b0;
      tmr_val_s  = {TMR_W{1'b0}};
      if ((state_r == ST_COLLECT) && accept_s && last_s) begin
         tmr_load_s = 1'b1;
         tmr_val_s  = TMR_W'(SETUP_CYCLES - 1);
      end else if (state_r == ST_STROBE) begin
         tmr_load_s = 1'b1;
         tmr_val_s  = TMR_W'(HOLD_CYCLES - 1);
      end else begin
         tmr_load_s = 1'b0;
         tmr_val_s  = {TMR_W{1'b0}};
      end
   end

   cfg_hold_timer #(
      .W (TMR_W)
   ) u_timer (
      .CLK      (CLK),
      .resetn   (resetn),
      .load     (tmr_load_s),
      .load_val (tmr_val_s),
      .expired  (tmr_expired_s)
   );

   // load sequencer FSM with packer, byte/word counters and registered outputs
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         state_r    <= ST_IDLE;
         rem_r      <= {LEN_W{1'b0}};
         pack_r     <= {CFG_WORD_W{1'b0}};
         idx_r      <= 2'd0;
         wdata_r    <= {CFG_WORD_W{1'b0}};
         in_ready_r <= 1'b0;
         strobe_r   <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         ww_r       <= {CNT_W{1'b0}};
      end else begin
         strobe_r <= 1'b0;
         done_r   <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  ww_r   <= {CNT_W{1'b0}};
                  busy_r <= 1'b1;
                  if (byte_count != {LEN_W{1'b0}}) begin
                     rem_r      <= byte_count;
                     pack_r     <= {CFG_WORD_W{1'b0}};
                     idx_r      <= 2'd0;
                     in_ready_r <= 1'b1;
                     state_r    <= ST_COLLECT;
                  end else begin
                     done_r  <= 1'b1;
                     state_r <= ST_DONE;
                  end
               end
            end
            ST_COLLECT: begin
               if (accept_s) begin
                  rem_r <= rem_r - LEN_W'(1);
                  if (last_s) begin
                     // packer was cleared, so unfilled low lanes go out as zero
                     wdata_r    <= packed_s;
                     pack_r     <= {CFG_WORD_W{1'b0}};
                     idx_r      <= 2'd0;
                     in_ready_r <= 1'b0;
                     state_r    <= ST_SETUP;
                  end else begin
                     pack_r <= packed_s;
                     idx_r  <= idx_r + 2'd1;
                  end
               end
            end
            ST_SETUP: begin
               if (tmr_expired_s) begin
                  strobe_r <= 1'b1;
                  state_r  <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (ww_r != {CNT_W{1'b1}}) begin
                  ww_r <= ww_r + CNT_W'(1);
               end
               state_r <= ST_HOLD;
            end
            ST_HOLD: begin
               if (tmr_expired_s) begin
                  if (rem_r != {LEN_W{1'b0}}) begin
                     in_ready_r <= 1'b1;
                     state_r    <= ST_COLLECT;
                  end else begin
                     done_r  <= 1'b1;
                     state_r <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r     <= 1'b0;
               in_ready_r <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready        = in_ready_r;
   assign SelfWriteData   = wdata_r;
   assign SelfWriteStrobe = strobe_r;
   assign busy            = busy_r;
   assign done            = done_r;
   assign words_written   = ww_r;

endmodule

// File: tb/tb_cfg_word_loader.sv
// Directed bench for cfg_word_loader: streams byte sequences and checks words, spacing and control pulses.
// A negedge monitor logs every strobe and done pulse and tracks data stability around strobes.
module tb_cfg_word_loader;

   localparam int SETUP = 2;
   localparam int HOLD  = 2;
   localparam int LEN_W = 16;

   logic              CLK = 1'b0;
   logic              resetn;
   logic              start;
   logic [LEN_W-1:0]  byte_count;
   logic [7:0]        in_byte;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       SelfWriteData;
   logic              SelfWriteStrobe;
   logic              busy;
   logic              done;
   logic [LEN_W-3:0]  words_written;

   int          tests_run    = 0;
   int          tests_failed = 0;
   int          cyc          = 0;
   logic [31:0] strobe_data[$];
   int          strobe_cyc[$];
   int          done_cnt     = 0;
   int          done_cyc     = 0;
   int          since_change = 100;
   int          since_strobe = 100;
   int          setup_viol   = 0;
   int          hold_viol    = 0;
   logic [31:0] prev_data    = 32'h0;
   logic [7:0]  src_bytes [0:15];
   int          src_n        = 0;
   bit          bursty       = 1'b0;
   bit          abort        = 1'b0;
   logic [7:0]  lfsr         = 8'hA5;
   int          t_start      = 0;
   int          base_done    = 0;
   int          base_strb    = 0;

   cfg_word_loader #(
      .SETUP_CYCLES (SETUP),
      .HOLD_CYCLES  (HOLD),
      .LEN_W        (LEN_W)
   ) dut (
      .CLK             (CLK),
      .resetn          (resetn),
      .start           (start),
      .byte_count      (byte_count),
      .in_byte         (in_byte),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .SelfWriteData   (SelfWriteData),
      .SelfWriteStrobe (SelfWriteStrobe),
      .busy            (busy),
      .done            (done),
      .words_written   (words_written)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // strobe/done logger and setup/hold stability tracker
   always @(negedge CLK) begin
      if (SelfWriteStrobe) begin
         strobe_data.push_back(SelfWriteData);
         strobe_cyc.push_back(cyc);
         if ((SelfWriteData !== prev_data) || (since_change + 1 < SETUP)) setup_viol <= setup_viol + 1;
         since_strobe <= 0;
      end else begin
         if ((SelfWriteData !== prev_data) && (since_strobe < HOLD)) hold_viol <= hold_viol + 1;
         since_strobe <= since_strobe + 1;
      end
      since_change <= (SelfWriteData !== prev_data) ? 0 : since_change + 1;
      prev_data    <= SelfWriteData;
      if (done) begin
         done_cnt <= done_cnt + 1;
         done_cyc <= cyc;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic begin_test();
      base_done = done_cnt;
      base_strb = strobe_data.size();
      abort     = 1'b0;
   endtask

   task automatic set_bytes(input int n, input logic [7:0] first, input logic [7:0] step);
      logic [7:0] b;
      b = first;
      for (int i = 0; i < n; i++) begin
         src_bytes[i] = b;
         b = b + step;
      end
      src_n = n;
   endtask

   task automatic do_start(input logic [LEN_W-1:0] c);
      start      = 1'b1;
      byte_count = c;
      @(posedge CLK);
      #1;
      t_start    = cyc;
      start      = 1'b0;
      byte_count = 16'h0000;
   endtask

   task automatic feed();
      int i     = 0;
      int guard = 0;
      bit hs;
      while ((i < src_n) && !abort && (guard < 400)) begin
         in_byte = src_bytes[i];
         if (bursty) begin
            in_valid = lfsr[0];
            lfsr     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
         end else begin
            in_valid = 1'b1;
         end
         @(negedge CLK);
         hs = in_valid && in_ready;
         @(posedge CLK);
         #1;
         if (hs) i++;
         guard++;
      end
      in_valid = 1'b0;
      if (!abort) check_val("feed_count", i, src_n);
   endtask

   task automatic wait_done(input bit chk_start);
      int n = 0;
      @(negedge CLK);
      if (chk_start) begin
         check_val("busy_after_start", {31'h0, busy}, 32'h1);
         check_val("ready_after_start", {31'h0, in_ready}, 32'h1);
      end
      while ((done_cnt == base_done) && (n < 400)) begin
         @(negedge CLK);
         n++;
      end
      check_val("done_seen", {31'h0, (done_cnt != base_done)}, 32'h1);
      check_val("busy_after_done", {31'h0, busy}, 32'h0);
   endtask

   task automatic check_words(input string tag, input int n, input logic [31:0] w0,
                              input logic [31:0] w1, input logic [31:0] w2);
      logic [31:0] exp_w [0:2];
      exp_w[0] = w0;
      exp_w[1] = w1;
      exp_w[2] = w2;
      check_val({tag, "_strobes"}, strobe_data.size() - base_strb, n);
      check_val({tag, "_dones"}, done_cnt - base_done, 32'h1);
      check_val({tag, "_words_written"}, {16'h0, 2'b00, words_written}, n);
      if (strobe_data.size() >= base_strb + n) begin
         for (int i = 0; i < n; i++) check_val({tag, "_word"}, strobe_data[base_strb + i], exp_w[i]);
         check_val({tag, "_done_after_strobe"}, done_cyc - strobe_cyc[base_strb + n - 1], HOLD + 1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn     = 1'b0;
      start      = 1'b0;
      byte_count = 16'h0000;
      in_byte    = 8'h00;
      in_valid   = 1'b0;
      repeat (2) @(negedge CLK);
      check_val("rst_in_ready", {31'h0, in_ready}, 32'h0);
      check_val("rst_data", SelfWriteData, 32'h0);
      check_val("rst_strobe", {31'h0, SelfWriteStrobe}, 32'h0);
      check_val("rst_busy", {31'h0, busy}, 32'h0);
      check_val("rst_done", {31'h0, done}, 32'h0);
      check_val("rst_ww", {16'h0, 2'b00, words_written}, 32'h0);
      @(posedge CLK); #1;
      resetn = 1'b1;
      @(posedge CLK); #1;

      // basic contiguous load of two full words
      begin_test();
      set_bytes(8, 8'h01, 8'h01);
      bursty = 1'b0;
      do_start(16'd8);
      fork
         feed();
         wait_done(1'b1);
      join
      repeat (4) @(negedge CLK);
      check_words("basic", 2, 32'h01020304, 32'h05060708, 32'h0);
      if (strobe_data.size() >= base_strb + 2) begin
         check_val("basic_first_strobe", strobe_cyc[base_strb] - t_start, 4 + SETUP);
         check_val("basic_strobe_gap", strobe_cyc[base_strb + 1] - strobe_cyc[base_strb], 4 + SETUP + 1 + HOLD);
      end
      check_val("basic_data_held", SelfWriteData, 32'h05060708);

      // partial final word is zero padded
      @(posedge CLK); #1;
      begin_test();
      set_bytes(5, 8'hAA, 8'h11);
      do_start(16'd5);
      fork
         feed();
         wait_done(1'b1);
      join
      repeat (4) @(negedge CLK);
      check_words("partial", 2, 32'hAABBCCDD, 32'hEE000000, 32'h0);

      // bursty source yields identical words with no loss
      @(posedge CLK); #1;
      begin_test();
      set_bytes(12, 8'h10, 8'h01);
      bursty = 1'b1;
      do_start(16'd12);
      fork
         feed();
         wait_done(1'b1);
      join
      bursty = 1'b0;
      repeat (4) @(negedge CLK);
      check_words("bursty", 3, 32'h10111213, 32'h14151617, 32'h18191A1B);
      check_val("bursty_setup_viol", setup_viol, 32'h0);
      check_val("bursty_hold_viol", hold_viol, 32'h0);

      // zero length load
      @(posedge CLK); #1;
      begin_test();
      do_start(16'd0);
      @(negedge CLK);
      check_val("zero_done", {31'h0, done}, 32'h1);
      check_val("zero_busy", {31'h0, busy}, 32'h1);
      check_val("zero_ready", {31'h0, in_ready}, 32'h0);
      @(negedge CLK);
      check_val("zero_done_fall", {31'h0, done}, 32'h0);
      check_val("zero_busy_fall", {31'h0, busy}, 32'h0);
      check_val("zero_ready_low", {31'h0, in_ready}, 32'h0);
      repeat (4) @(negedge CLK);
      check_val("zero_strobes", strobe_data.size() - base_strb, 32'h0);
      check_val("zero_done_cyc", done_cyc - t_start, 32'h0);
      check_val("zero_dones", done_cnt - base_done, 32'h1);
      check_val("zero_ww", {16'h0, 2'b00, words_written}, 32'h0);

      // start pulsed during HOLD of word 1 is ignored
      @(posedge CLK); #1;
      begin_test();
      set_bytes(8, 8'h21, 8'h01);
      do_start(16'd8);
      fork
         feed();
         begin
            int n = 0;
            while ((strobe_data.size() == base_strb) && (n < 200)) begin
               @(negedge CLK);
               n++;
            end
            @(posedge CLK); #1;
            start      = 1'b1;
            byte_count = 16'd4;
            @(posedge CLK); #1;
            start      = 1'b0;
            byte_count = 16'h0000;
            wait_done(1'b0);
         end
      join
      repeat (4) @(negedge CLK);
      check_words("busy_start", 2, 32'h21222324, 32'h25262728, 32'h0);

      // reset during SETUP of word 2
      @(posedge CLK); #1;
      begin_test();
      set_bytes(8, 8'h31, 8'h01);
      do_start(16'd8);
      fork
         feed();
         begin
            int n = 0;
            while ((SelfWriteData !== 32'h35363738) && (n < 200)) begin
               @(negedge CLK);
               n++;
            end
            check_val("rst_mid_reach", SelfWriteData, 32'h35363738);
            #2;
            resetn = 1'b0;
            abort  = 1'b1;
            #1;
            check_val("rst_mid_ready", {31'h0, in_ready}, 32'h0);
            check_val("rst_mid_data", SelfWriteData, 32'h0);
            check_val("rst_mid_strobe", {31'h0, SelfWriteStrobe}, 32'h0);
            check_val("rst_mid_busy", {31'h0, busy}, 32'h0);
            check_val("rst_mid_ww", {16'h0, 2'b00, words_written}, 32'h0);
         end
      join
      repeat (6) @(negedge CLK);
      check_val("rst_mid_strobes", strobe_data.size() - base_strb, 32'h1);
      check_val("rst_mid_no_done", done_cnt - base_done, 32'h0);
      @(posedge CLK); #1;
      resetn = 1'b1;
      @(posedge CLK); #1;
      begin_test();
      set_bytes(4, 8'h41, 8'h01);
      do_start(16'd4);
      fork
         feed();
         wait_done(1'b1);
      join
      repeat (4) @(negedge CLK);
      check_words("after_rst", 1, 32'h41424344, 32'h0, 32'h0);
      check_val("all_setup_viol", setup_viol, 32'h0);
      check_val("all_hold_viol", hold_viol, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
